inst_encoder: RTL and testbench
===============================

# inst_encoder

Instruction encoder and instruction-memory writer for the SCPU. It accepts field-level instruction requests over a valid/ready handshake and packs them into 32-bit RV32I words, covering the same subset the control decoder handles: OP-IMM, LOAD, STORE, BEQ/BNE, LUI, JAL and OP. Each legal word is written into instruction memory at an auto-incrementing address. It is used to load test programs and self-test images ahead of core execution.

## Interface
Parameters:
- ADDR_W, 8, imem word-address width; capacity is 2^ADDR_W words.

Ports:
- clk  in  1  clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  encoder can accept a request.
- req_kind  in  3  0 OP_IMM, 1 LOAD, 2 STORE, 3 BRANCH, 4 LUI, 5 JAL, 6 OP, 7 reserved.
- req_funct3  in  3  funct3 for OP_IMM, OP and BRANCH; ignored otherwise.
- req_funct7_5  in  1  funct7[5] for OP, and for OP_IMM shifts.
- req_rd, req_rs1, req_rs2  in  5 each  register indices.
- req_imm  in  32  byte-offset or immediate value, two's complement.
- seal  in  1  level signal: finish the program.
- imem_we  out  1  write strobe, one cycle per word.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  encoded instruction.
- count  out  ADDR_W+1  number of words written.
- full  out  1  count == 2^ADDR_W.
- err  out  1  sticky flag: an illegal request was seen.
- done  out  1  sealed; the block is inert until reset.

## Operation
FSM states: IDLE, WRITE, FULL, TERM, DONE.

IDLE
- req_ready = 1.
- valid & ready: register the encoded word, go to WRITE.
- seal with no valid: go to TERM.
- valid and seal in the same cycle: the request wins. Seal is honoured on a later IDLE cycle only if still held.

WRITE
- If the request was legal: imem_we = 1, imem_addr = wr_ptr. Then wr_ptr++ and count++.
- If the request was illegal: no write, and err is set.
- Next state is FULL if count reaches 2^ADDR_W, otherwise IDLE.

FULL
- req_ready = 0.
- seal: go to DONE with no terminator written.

TERM
- Write terminator 0x0000006F (jal x0,0) at wr_ptr, count++, then go to DONE.

DONE
- req_ready = 0, done = 1. Leaves only on reset.

Encoding rules:
- OP_IMM: imm[11:0]. For funct3 001, imm[11:5] is forced to 0. For funct3 101, imm[11:5] is forced to {0, funct7_5, 00000}.
- LOAD: funct3 forced to 010, I-type format.
- STORE: funct3 forced to 010, S-type format with imm split as [11:5] and [4:0].
- BRANCH: B-type format. Illegal if funct3 is not 000 or 001, or if imm[0] = 1.
- LUI: imm[31:12].
- JAL: J-type format. Illegal if imm[0] = 1.
- OP: funct7 = {0, funct7_5, 00000}.
- Range checks: I and S immediates must sign-fit in 12 bits, B in 13 bits, J in 21 bits. Anything outside is illegal.
- Kind 7 is illegal.
- Opcodes match the decoder's exactly.

## Timing
Reset values (asynchronous):
- state IDLE.
- req_ready 0; it rises on the first clk edge after rst_n deasserts.
- imem_we 0, imem_addr 0, imem_wdata 0.
- count 0, wr_ptr 0, full 0, err 0, done 0.

Handshake:
- Accept happens at edge N, when valid & ready are sampled.
- Cycle N+1: req_ready = 0 and imem_we = 1 (legal requests only), with addr/wdata stable.
- Edge N+1: the ready pulse ends; count is updated.
- Throughput: one request per 2 cycles.

Outputs:
- imem_we, imem_addr, imem_wdata, count, full, err and done are all registered.
- imem_wdata holds its last value after the write.

Reset during WRITE or TERM:
- imem_we drops immediately and count returns to 0.
- The in-flight word is not retried.

## Structure
- Package scpu_enc_pkg:
  - opcode constants, shared with the decoder: 0010011, 0000011, 0100011, 1100011, 0110111, 1101111, 0110011.
  - req_kind enum.
  - TERMINATOR constant.
  - FSM state typedef.
- Sub-module inst_field_pack: purely combinational, maps (kind, fields, imm) to {word, illegal}. It is reusable by a future disassembler checker.

## Test plan
1. addi x1,x0,5 (kind 0, f3 000, rd 1, imm 5) -> imem_we for one cycle, addr 0, wdata 0x00500093, count 1, ready low exactly one cycle.
2. sw x2,8(x1) (kind 2, rs1 1, rs2 2, imm 8) -> 0x0020A423 at addr 1. Then lui x5,0x12345000 -> 0x123452B7 at addr 2.
3. beq x1,x2,-4 -> 0xFE208EE3. Branch with f3 010, then jal with imm 3 -> no imem_we, err = 1 and sticky, count unchanged.
4. ADDR_W = 2:
   - 4 legal requests -> full = 1, ready stays 0, and a valid held high produces no write.
   - seal -> done = 1 with no terminator written.
5. One word written, then seal with valid low -> 0x0000006F written at addr 1, count 2, done = 1. Valid and seal asserted together in IDLE -> the request is written first.
6. rst_n pulled low during the WRITE cycle -> imem_we = 0 immediately, count = 0, err = 0. After release, ready = 1 on the first edge and the next write goes to addr 0.

Source files
------------

// File: rtl/scpu_enc_pkg.sv
// Shared encoding constants and types for the SCPU instruction encoder.
// Opcode values must stay identical to those in the control decoder.
package scpu_enc_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [31:0] TERMINATOR = 32'h0000006F;  // jal x0,0

  typedef enum logic [2:0] {
    K_OP_IMM = 3'd0, K_LOAD = 3'd1, K_STORE = 3'd2, K_BRANCH = 3'd3,
    K_LUI    = 3'd4, K_JAL  = 3'd5, K_OP    = 3'd6, K_RSVD   = 3'd7
  } req_kind_e;

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_FULL, S_TERM, S_DONE
  } enc_state_e;

  // True when v is representable as an n-bit two's complement value.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned n);
    logic [31:0] hi;
    hi = $unsigned($signed(v) >>> (n - 1));
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/inst_field_pack.sv
// Combinational RV32I field packer: (kind, fields, imm) -> {word, illegal}.
module inst_field_pack
  import scpu_enc_pkg::*;
(
  input  logic [2:0]  kind_i,
  input  logic [2:0]  funct3_i,
  input  logic        funct7_5_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  req_kind_e  kind;
  logic [6:0] f7;

  assign kind = req_kind_e'(kind_i);

  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    f7        = imm_i[11:5];
    case (kind)
      K_OP_IMM: begin
        // Shift immediates carry funct7 in imm[11:5].
        if (funct3_i == 3'b001)      f7 = 7'b0;
        else if (funct3_i == 3'b101) f7 = {1'b0, funct7_5_i, 5'b0};
        word_o    = {f7, imm_i[4:0], rs1_i, funct3_i, rd_i, OPC_OP_IMM};
        illegal_o = !fits_signed(imm_i, 12);
      end
      K_LOAD: begin
        word_o    = {imm_i[11:0], rs1_i, 3'b010, rd_i, OPC_LOAD};
        illegal_o = !fits_signed(imm_i, 12);
      end
      K_STORE: begin
        word_o    = {imm_i[11:5], rs2_i, rs1_i, 3'b010, imm_i[4:0], OPC_STORE};
        illegal_o = !fits_signed(imm_i, 12);
      end
      K_BRANCH: begin
        word_o    = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                     imm_i[4:1], imm_i[11], OPC_BRANCH};
        illegal_o = (funct3_i[2:1] != 2'b00) || imm_i[0] || !fits_signed(imm_i, 13);
      end
      K_LUI: begin
        word_o    = {imm_i[31:12], rd_i, OPC_LUI};
      end
      K_JAL: begin
        word_o    = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OPC_JAL};
        illegal_o = imm_i[0] || !fits_signed(imm_i, 21);
      end
      K_OP: begin
        word_o    = {1'b0, funct7_5_i, 5'b0, rs2_i, rs1_i, funct3_i, rd_i, OPC_OP};
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder: accepts field-level requests and writes packed RV32I
// words into instruction memory at an auto-incrementing word address.
module inst_encoder
  import scpu_enc_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_kind,
  input  logic [2:0]        req_funct3,
  input  logic              req_funct7_5,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [31:0]       req_imm,
  input  logic              seal,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err,
  output logic              done
);

  localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

  enc_state_e        state_q;
  logic              ready_q, we_q, full_q, err_q, done_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] wr_ptr;
  logic [31:0]       pk_word;
  logic              pk_illegal;

  inst_field_pack u_pack (
    .kind_i     (req_kind),
    .funct3_i   (req_funct3),
    .funct7_5_i (req_funct7_5),
    .rd_i       (req_rd),
    .rs1_i      (req_rs1),
    .rs2_i      (req_rs2),
    .imm_i      (req_imm),
    .word_o     (pk_word),
    .illegal_o  (pk_illegal)
  );

  // Every write bumps both together, so the pointer is the count's low bits.
  assign wr_ptr  = count_q[ADDR_W-1:0];
  assign count_d = count_q + {{ADDR_W{1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid && ready_q) begin
            state_q <= S_WRITE;
            ready_q <= 1'b0;
            we_q    <= !pk_illegal;
            addr_q  <= wr_ptr;
            if (!pk_illegal) wdata_q <= pk_word;
          end else if (seal) begin
            state_q <= S_TERM;
            ready_q <= 1'b0;
            we_q    <= 1'b1;
            addr_q  <= wr_ptr;
            wdata_q <= TERMINATOR;
          end else begin
            ready_q <= 1'b1;
          end
        end
        S_WRITE: begin
          // we_q doubles as the "request was legal" marker for this cycle.
          we_q <= 1'b0;
          if (we_q) begin
            count_q <= count_d;
            full_q  <= (count_d == CAP);
          end else begin
            err_q <= 1'b1;
          end
          if (we_q && count_d == CAP) begin
            state_q <= S_FULL;
          end else begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
          end
        end
        S_FULL: begin
          if (seal) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_TERM: begin
          we_q    <= 1'b0;
          count_q <= count_d;
          full_q  <= (count_d == CAP);
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: ;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign full       = full_q;
  assign err        = err_q;
  assign done       = done_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: directed requests push expected writes,
// a negedge monitor pops and compares every imem write.
module tb_inst_encoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        valid, seal, valid_s, seal_s;
  logic [2:0]  kind, f3;
  logic        f7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;

  logic        ready, we, full, err, done;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [8:0]  count;

  logic        ready_s, we_s, full_s, err_s, done_s;
  logic [1:0]  addr_s;
  logic [31:0] wdata_s;
  logic [2:0]  count_s;

  int passed = 0;
  int total = 0;
  int s_writes = 0;
  logic [39:0] exp_q[$];
  logic [39:0] e;

  inst_encoder #(.ADDR_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(valid), .req_ready(ready),
    .req_kind(kind), .req_funct3(f3), .req_funct7_5(f7), .req_rd(rd),
    .req_rs1(rs1), .req_rs2(rs2), .req_imm(imm), .seal(seal),
    .imem_we(we), .imem_addr(addr), .imem_wdata(wdata), .count(count),
    .full(full), .err(err), .done(done)
  );

  inst_encoder #(.ADDR_W(2)) u_small (
    .clk(clk), .rst_n(rst_n), .req_valid(valid_s), .req_ready(ready_s),
    .req_kind(kind), .req_funct3(f3), .req_funct7_5(f7), .req_rd(rd),
    .req_rs1(rs1), .req_rs2(rs2), .req_imm(imm), .seal(seal_s),
    .imem_we(we_s), .imem_addr(addr_s), .imem_wdata(wdata_s), .count(count_s),
    .full(full_s), .err(err_s), .done(done_s)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic expect_wr(input logic [7:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  // Waits (bounded) for ready, presents one request for one accepting edge,
  // and returns 1 time unit after that edge.
  task automatic send(input bit sm, input logic [2:0] k, input logic [2:0] fn3,
                      input logic fn7, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [31:0] im);
    int n;
    kind = k; f3 = fn3; f7 = fn7; rd = d; rs1 = s1; rs2 = s2; imm = im;
    n = 0;
    while (!(sm ? ready_s : ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) begin
      total++;
      $display("FAIL ready_timeout: got ready low for %0d cycles expected high", n);
    end
    if (sm) valid_s = 1'b1; else valid = 1'b1;
    @(posedge clk);
    #1;
    if (sm) valid_s = 1'b0; else valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (we === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", addr, wdata);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(addr), 32'(e[39:32]));
        chk("wr_data", wdata, e[31:0]);
      end
    end
  end

  always @(negedge clk) if (we_s === 1'b1) s_writes++;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    valid = 0; seal = 0; valid_s = 0; seal_s = 0;
    kind = 0; f3 = 0; f7 = 0; rd = 0; rs1 = 0; rs2 = 0; imm = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_we", 32'(we), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_flags", {28'b0, full, err, done, 1'b0}, 0);
    rst_n = 1;
    @(posedge clk); #1;
    chk("ready_after_rst", 32'(ready), 1);

    // addi x1,x0,5; ready low exactly one cycle
    expect_wr(8'd0, 32'h00500093);
    send(0, 3'd0, 3'b000, 0, 5'd1, 5'd0, 5'd0, 32'd5);
    chk("ready_low", 32'(ready), 0);
    @(posedge clk); #1;
    chk("ready_back", 32'(ready), 1);
    chk("count_1", 32'(count), 1);

    expect_wr(8'd1, 32'h0020A423);            // sw x2,8(x1)
    send(0, 3'd2, 3'b000, 0, 5'd0, 5'd1, 5'd2, 32'd8);
    expect_wr(8'd2, 32'h123452B7);            // lui x5,0x12345
    send(0, 3'd4, 3'b000, 0, 5'd5, 5'd0, 5'd0, 32'h12345000);
    expect_wr(8'd3, 32'hFE208EE3);            // beq x1,x2,-4
    send(0, 3'd3, 3'b000, 0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC);
    expect_wr(8'd4, 32'h4040D193);            // srai x3,x1,4
    send(0, 3'd0, 3'b101, 1, 5'd3, 5'd1, 5'd0, 32'd4);
    expect_wr(8'd5, 32'h40208233);            // sub x4,x1,x2
    send(0, 3'd6, 3'b000, 1, 5'd4, 5'd1, 5'd2, 32'd0);
    expect_wr(8'd6, 32'h008000EF);            // jal x1,8
    send(0, 3'd5, 3'b000, 0, 5'd1, 5'd0, 5'd0, 32'd8);
    @(posedge clk); #1;
    chk("count_7", 32'(count), 7);
    chk("err_clear", 32'(err), 0);

    // illegal: branch f3 010, jal odd offset, addi out of range
    send(0, 3'd3, 3'b010, 0, 5'd0, 5'd1, 5'd2, 32'd8);
    @(posedge clk); #1;
    chk("err_branch_f3", 32'(err), 1);
    chk("count_after_ill", 32'(count), 7);
    send(0, 3'd5, 3'b000, 0, 5'd1, 5'd0, 5'd0, 32'd3);
    @(posedge clk); #1;
    chk("err_sticky", 32'(err), 1);
    send(0, 3'd0, 3'b000, 0, 5'd1, 5'd0, 5'd0, 32'd2048);
    @(posedge clk); #1;
    chk("count_after_range", 32'(count), 7);

    // reset during WRITE: in-flight word dropped
    send(0, 3'd0, 3'b000, 0, 5'd1, 5'd0, 5'd0, 32'd5);
    #2 rst_n = 0;
    #1;
    chk("rstw_we", 32'(we), 0);
    chk("rstw_count", 32'(count), 0);
    chk("rstw_err", 32'(err), 0);
    @(negedge clk);
    rst_n = 1;
    chk("rstw_ready_low", 32'(ready), 0);
    @(posedge clk); #1;
    chk("rstw_ready_high", 32'(ready), 1);

    // one word then seal -> terminator at addr 1
    expect_wr(8'd0, 32'h00500093);
    send(0, 3'd0, 3'b000, 0, 5'd1, 5'd0, 5'd0, 32'd5);
    @(posedge clk); #1;
    expect_wr(8'd1, 32'h0000006F);
    seal = 1;
    @(posedge clk); #1;
    seal = 0;
    @(posedge clk); #1;
    chk("term_count", 32'(count), 2);
    chk("term_done", 32'(done), 1);
    chk("done_ready", 32'(ready), 0);

    // valid and seal together: request first, then terminator
    @(negedge clk) rst_n = 0;
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    expect_wr(8'd0, 32'h00500093);
    expect_wr(8'd1, 32'h0000006F);
    seal = 1;
    send(0, 3'd0, 3'b000, 0, 5'd1, 5'd0, 5'd0, 32'd5);
    repeat (3) @(posedge clk);
    #1;
    seal = 0;
    chk("both_count", 32'(count), 2);
    chk("both_done", 32'(done), 1);
    @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 0);

    // ADDR_W=2: fill, stall, seal without terminator
    @(negedge clk) rst_n = 0;
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) send(1, 3'd0, 3'b000, 0, 5'd1, 5'd0, 5'd0, 32'(i));
    @(posedge clk); #1;
    chk("s_full", 32'(full_s), 1);
    chk("s_ready", 32'(ready_s), 0);
    chk("s_count", 32'(count_s), 4);
    valid_s = 1;
    repeat (4) @(posedge clk);
    #1;
    valid_s = 0;
    chk("s_no_write", 32'(s_writes), 4);
    seal_s = 1;
    @(posedge clk); #1;
    seal_s = 0;
    chk("s_done", 32'(done_s), 1);
    repeat (2) @(posedge clk);
    #1;
    chk("s_no_term", 32'(s_writes), 4);
    chk("s_count_final", 32'(count_s), 4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
